// File: rtl/weight_pkg.sv
// Shared constants and FSM state type for the weight SRAM loader.
package weight_pkg;
  localparam int DATA_WIDTH      = 8;
  localparam int DATA_LENGTH     = 8;
  localparam int SRAM_DATA_WIDTH = DATA_WIDTH * DATA_LENGTH;
  localparam int ADDR_WIDTH      = 8;
  localparam int LANE_WIDTH      = $clog2(DATA_LENGTH);
  localparam int CNT_WIDTH       = ADDR_WIDTH + LANE_WIDTH;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} loader_state_t;
endpackage

// File: rtl/weight_sram_loader_byte_packer.sv
// Packs weight bytes into lanes of one SRAM word; o_word already merges the incoming byte,
// so the parent can register the full word in the acceptance cycle (no backpressure here).
module byte_packer
  import weight_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_clear,
  input  logic                       i_push,
  input  logic                       i_close,
  input  logic [DATA_WIDTH-1:0]      i_data,
  output logic [SRAM_DATA_WIDTH-1:0] o_word,
  output logic                       o_word_valid
);
  logic [SRAM_DATA_WIDTH-1:0] buf_q;
  logic [LANE_WIDTH-1:0]      lane_q;

  always_comb begin
    o_word = buf_q;
    o_word[int'(lane_q)*DATA_WIDTH +: DATA_WIDTH] = i_data;
  end

  assign o_word_valid = i_push & (lane_q == LANE_WIDTH'(DATA_LENGTH - 1));

  // A completed or closed word empties the buffer so the next byte lands in lane 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      buf_q  <= '0;
      lane_q <= '0;
    end else if (i_clear || (i_push && (o_word_valid || i_close))) begin
      buf_q  <= '0;
      lane_q <= '0;
    end else if (i_push) begin
      buf_q  <= o_word;
      lane_q <= lane_q + 1'b1;
    end
  end
endmodule

// File: rtl/weight_sram_loader.sv
// Byte-serial to 64-bit SRAM word loader; write strobe 1 cycle after a word's last byte.
// o_ready is high only in LOAD, one byte per cycle sustained; partial final word flushed zero-padded.
module weight_sram_loader
  import weight_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_clear,
  input  logic                       i_start,
  input  logic [ADDR_WIDTH-1:0]      i_base_addr,
  input  logic [CNT_WIDTH-1:0]       i_byte_count,
  input  logic [DATA_WIDTH-1:0]      i_data,
  input  logic                       i_valid,
  output logic                       o_ready,
  output logic                       o_sram_write_en,
  output logic [ADDR_WIDTH-1:0]      o_sram_addr,
  output logic [SRAM_DATA_WIDTH-1:0] o_sram_data,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [ADDR_WIDTH:0]        o_words_written
);
  loader_state_t              state_q, state_d;
  logic [ADDR_WIDTH-1:0]      addr_q;
  logic [CNT_WIDTH-1:0]       bytes_rem_q;
  logic [SRAM_DATA_WIDTH-1:0] packed_word;
  logic                       start_ok, accept, last_byte, word_valid, emit;

  assign start_ok  = i_start & ((state_q == IDLE) | (state_q == DONE));
  assign accept    = i_valid & o_ready & ~i_clear;
  assign last_byte = accept & (bytes_rem_q == CNT_WIDTH'(1));
  assign emit      = word_valid | last_byte;

  byte_packer u_packer (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (i_clear | start_ok),
    .i_push       (accept),
    .i_close      (last_byte),
    .i_data       (i_data),
    .o_word       (packed_word),
    .o_word_valid (word_valid)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (i_start) state_d = (i_byte_count == '0) ? DONE : LOAD;
      LOAD:       if (last_byte) state_d = FLUSH;
      FLUSH:      state_d = DONE;
    endcase
    if (i_clear) state_d = IDLE;
  end

  always_comb begin
    o_ready = (state_q == LOAD);
    o_busy  = (state_q == LOAD) | (state_q == FLUSH);
    o_done  = (state_q == DONE);
  end

  // Address counter runs modulo 2^ADDR_WIDTH so a load may wrap past the top of the SRAM.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr_q          <= '0;
      bytes_rem_q     <= '0;
      o_sram_write_en <= 1'b0;
      o_sram_addr     <= '0;
      o_sram_data     <= '0;
      o_words_written <= '0;
    end else begin
      o_sram_write_en <= 1'b0;
      if (i_clear) begin
        bytes_rem_q <= '0;
      end else if (start_ok) begin
        addr_q          <= i_base_addr;
        bytes_rem_q     <= i_byte_count;
        o_words_written <= '0;
      end else if (accept) begin
        bytes_rem_q <= bytes_rem_q - 1'b1;
        if (emit) begin
          o_sram_write_en <= 1'b1;
          o_sram_addr     <= addr_q;
          o_sram_data     <= packed_word;
          addr_q          <= addr_q + 1'b1;
          o_words_written <= o_words_written + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_weight_sram_loader.sv
// Directed bench for weight_sram_loader: expected SRAM writes queued by stimulus, checked by a monitor.
module tb_weight_sram_loader;
  logic        i_clk = 1'b0;
  logic        i_rst, i_clear, i_start, i_valid;
  logic [7:0]  i_base_addr, i_data;
  logic [10:0] i_byte_count;
  logic        o_ready, o_sram_write_en, o_busy, o_done;
  logic [7:0]  o_sram_addr;
  logic [63:0] o_sram_data;
  logic [8:0]  o_words_written;

  weight_sram_loader dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_clear(i_clear), .i_start(i_start),
    .i_base_addr(i_base_addr), .i_byte_count(i_byte_count), .i_data(i_data),
    .i_valid(i_valid), .o_ready(o_ready), .o_sram_write_en(o_sram_write_en),
    .o_sram_addr(o_sram_addr), .o_sram_data(o_sram_data), .o_busy(o_busy),
    .o_done(o_done), .o_words_written(o_words_written)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0]  addr;
    logic [63:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   cyc_q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   m_lane, m_rem;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic monitor();
    exp_t e;
    int   c;
    forever begin
      @(negedge i_clk);
      if (o_sram_write_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe_addr", {56'd0, o_sram_addr}, 64'hXX);
        end else begin
          e = exp_q.pop_front();
          check("strobe_addr", {56'd0, o_sram_addr}, {56'd0, e.addr});
          check("strobe_data", o_sram_data, e.data);
          c = (cyc_q.size() != 0) ? cyc_q.pop_front() : -1;
          check("strobe_latency_cycle", 64'(cyc), 64'(c));
        end
      end
    end
  endtask

  task automatic expect_word(input logic [7:0] addr, input logic [63:0] data);
    exp_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic start_load(input logic [7:0] base, input logic [10:0] cnt);
    i_base_addr  = base;
    i_byte_count = cnt;
    i_start      = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    m_lane  = 0;
    m_rem   = int'(cnt);
  endtask

  // Waits for o_ready, then holds the byte across one rising edge; records when a word should strobe.
  task automatic drive_byte(input logic [7:0] d, input bit gap);
    bit ok = 1'b0;
    i_valid = 1'b1;
    i_data  = d;
    for (int t = 0; t < 10 && !ok; t++) begin
      @(negedge i_clk);
      if (o_ready) begin
        @(posedge i_clk); #1;
        ok = 1'b1;
      end
    end
    i_valid = 1'b0;
    if (!ok) begin
      check("ready_timeout", 64'd0, 64'd1);
    end else begin
      m_lane++;
      m_rem--;
      if (m_lane == 8 || m_rem == 0) begin
        cyc_q.push_back(cyc);
        m_lane = 0;
      end
      if (gap) begin
        @(posedge i_clk); #1;
      end
    end
  endtask

  task automatic stream(input logic [7:0] first, input int n, input bit gap);
    for (int k = 0; k < n; k++) drive_byte(first + 8'(k), gap);
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge i_clk); #1;
    end
  endtask

  initial begin
    i_rst = 1'b1; i_clear = 1'b0; i_start = 1'b0; i_valid = 1'b0;
    i_base_addr = '0; i_byte_count = '0; i_data = '0;
    fork monitor(); join_none
    tick(2);
    check("reset_outputs_zero",
          {o_ready, o_sram_write_en, o_busy, o_done, o_words_written, o_sram_addr, 44'd0},
          64'd0);
    check("reset_data_zero", o_sram_data, 64'd0);
    i_rst = 1'b0;
    i_valid = 1'b1; i_data = 8'hEE;
    tick(2);
    check("idle_ready_low", {63'd0, o_ready}, 64'd0);
    i_valid = 1'b0;

    // 16 bytes back-to-back from base 0x10
    expect_word(8'h10, 64'h0706050403020100);
    expect_word(8'h11, 64'h0F0E0D0C0B0A0908);
    start_load(8'h10, 11'd16);
    check("load_busy", {62'd0, o_busy, o_ready}, 64'd3);
    stream(8'h00, 16, 1'b0);
    check("flush_cycle_ready_busy", {62'd0, o_busy, o_ready}, 64'd2);
    tick(1);
    check("done_after_16", {63'd0, o_done}, 64'd1);
    check("busy_low_in_done", {63'd0, o_busy}, 64'd0);
    check("words_16", {55'd0, o_words_written}, 64'd2);

    // 11 bytes: partial second word via FLUSH
    expect_word(8'h20, 64'hA7A6A5A4A3A2A1A0);
    expect_word(8'h21, 64'h0000000000AAA9A8);
    start_load(8'h20, 11'd11);
    check("done_drops_on_start", {63'd0, o_done}, 64'd0);
    stream(8'hA0, 11, 1'b0);
    check("ready_low_after_last", {63'd0, o_ready}, 64'd0);
    tick(1);
    check("words_11", {55'd0, o_words_written}, 64'd2);

    // zero-length load
    start_load(8'h30, 11'd0);
    check("count0_done", {62'd0, o_done, o_busy}, 64'd2);
    check("count0_words", {55'd0, o_words_written}, 64'd0);

    // address wrap
    expect_word(8'hFF, 64'h3736353433323130);
    expect_word(8'h00, 64'h3F3E3D3C3B3A3938);
    start_load(8'hFF, 11'd16);
    stream(8'h30, 16, 1'b0);
    tick(1);
    check("words_wrap", {55'd0, o_words_written}, 64'd2);

    // valid toggling every cycle
    expect_word(8'h40, 64'h6766656463626160);
    start_load(8'h40, 11'd8);
    stream(8'h60, 8, 1'b1);
    tick(1);
    check("toggle_done", {63'd0, o_done}, 64'd1);
    check("words_toggle", {55'd0, o_words_written}, 64'd1);

    // soft clear mid-word discards the partial word
    start_load(8'h50, 11'd16);
    stream(8'h11, 5, 1'b0);
    i_clear = 1'b1;
    tick(1);
    i_clear = 1'b0;
    check("clear_to_idle", {61'd0, o_ready, o_busy, o_done}, 64'd0);
    tick(3);
    expect_word(8'h50, 64'h8786858483828180);
    start_load(8'h50, 11'd8);
    stream(8'h80, 8, 1'b0);
    tick(1);
    check("words_after_clear", {55'd0, o_words_written}, 64'd1);

    // asynchronous reset mid-LOAD
    start_load(8'h60, 11'd16);
    stream(8'h90, 3, 1'b0);
    #2 i_rst = 1'b1;
    #1;
    check("async_rst_outputs",
          {o_ready, o_sram_write_en, o_busy, o_done, o_words_written, o_sram_addr, 44'd0},
          64'd0);
    check("async_rst_data", o_sram_data, 64'd0);
    tick(2);
    i_rst = 1'b0;
    tick(3);

    check("all_writes_seen", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
